// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO: configurable data bits, parity and stop bits.
// Words are accepted through a valid/ready port and sent as back-to-back frames, LSB first.
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   baud_end;
    logic [DATA_BITS-1:0]   head_word;

    // Handshake: a word is taken on any rising edge where tx_valid && tx_ready;
    // tx_ready depends only on the registered count, so the host sees a stable
    // ready for the whole cycle and must hold tx_data/tx_valid until accepted.
    assign tx_ready   = (count_q < DEPTH_C);
    assign push       = tx_valid && tx_ready;
    assign baud_end   = (baud_q == BAUD_LAST);
    assign head_word  = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    // Storage is not reset: occupancy lives entirely in the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = '0;
                end
            end

            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when work is queued.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (pop) begin
            shift_d = head_word;
            par_d   = (PARITY == 2) ? ~(^head_word) : (^head_word);
        end
    end

    // The line level is registered from the next state, so tx changes on the
    // same edge as the state and never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations, a serial-line monitor per instance
// that decodes frames and checks them against an expected-frame queue.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int CPB = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0] valid_w;
    logic [7:0] data_w [4];
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [2:0] cnt_w [4];

    // 0: 8N1   1: 8E1   2: 8O1   3: 7N2
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .tx_data(data_w[1]), .tx_valid(valid_w[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .reset(reset), .tx_data(data_w[2]), .tx_valid(valid_w[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .reset(reset), .tx_data(data_w[3][6:0]), .tx_valid(valid_w[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt_w[3]));

    // ---------------- scoreboard state ----------------
    logic [19:0] exp_q [$];   // {instance[3:0], frame bits LSB-first}
    int          start_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rst_epoch = 0;
    int          mon_active [4];

    function automatic int nbits(input int k);
        case (k)
            1, 2:    return 11;
            default: return 10;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- monitor ----------------
    task automatic rx_monitor(input int k);
        logic [15:0] got;
        logic [19:0] e;
        int          hold_bad;
        int          ep;
        int          st;
        forever begin
            @(negedge clk);
            if (reset && tx_w[k] == 1'b0) begin
                mon_active[k] = 1;
                ep       = rst_epoch;
                st       = cyc;
                got      = '0;
                hold_bad = 0;
                for (int b = 0; b < nbits(k); b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        if (c == 0) got[b] = tx_w[k];
                        else if (tx_w[k] !== got[b]) hold_bad++;
                    end
                end
                mon_active[k] = 0;
                if (ep == rst_epoch) begin
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame u%0d: got 0x%0h, expected none", k, got);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("frame_u%0d", k), {12'd0, 4'(k), got}, {12'd0, e});
                        check($sformatf("bit_hold_u%0d", k), hold_bad, 0);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_hold(input int k, input logic [7:0] d, input logic [15:0] frame,
                             input bit expect_it, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        data_w[k]  = d;
        valid_w[k] = 1'b1;
        while (ready_w[k] !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            fail_now($sformatf("push_timeout_u%0d", k));
            valid_w[k] = 1'b0;
            acc_cyc    = -1;
        end else begin
            if (expect_it) exp_q.push_back({4'(k), frame});
            @(posedge clk);
            #1;
            acc_cyc    = cyc;
            valid_w[k] = 1'b0;
        end
    endtask

    task automatic send_one(input int k, input logic [7:0] d, input logic [15:0] frame);
        int acc;
        int nb;
        nb = nbits(k);
        push_hold(k, d, frame, 1'b1, acc);
        check($sformatf("cnt_after_push_u%0d", k), cnt_w[k], 1);
        check($sformatf("tx_before_pop_u%0d", k), tx_w[k], 1);
        @(posedge clk); #1;
        check($sformatf("tx_fall_latency_u%0d", k), tx_w[k], 0);
        check($sformatf("cnt_after_pop_u%0d", k), cnt_w[k], 0);
        check($sformatf("busy_in_frame_u%0d", k), busy_w[k], 1);
        repeat (nb * CPB - 1) @(posedge clk);
        #1;
        check($sformatf("busy_last_cycle_u%0d", k), busy_w[k], 1);
        @(posedge clk); #1;
        check($sformatf("busy_after_frame_u%0d", k), busy_w[k], 0);
        check($sformatf("tx_idle_after_u%0d", k), tx_w[k], 1);
    endtask

    task automatic wait_idle(input int k);
        int w;
        w = 0;
        @(negedge clk);
        while ((busy_w[k] || mon_active[k] != 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) fail_now($sformatf("idle_timeout_u%0d", k));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0]  b2b_data  [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [15:0] b2b_frame [6] = '{16'h202, 16'h204, 16'h206, 16'h208, 16'h20A, 16'h20C};
    int          b2b_cnt   [5] = '{1, 1, 2, 3, 4};

    initial begin
        int acc;
        int lows;
        valid_w = '0;
        for (int i = 0; i < 4; i++) begin
            data_w[i]     = '0;
            mon_active[i] = 0;
        end
        fork
            rx_monitor(0);
            rx_monitor(1);
            rx_monitor(2);
            rx_monitor(3);
        join_none

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k += 3) begin
            check($sformatf("rst_tx_u%0d", k), tx_w[k], 1);
            check($sformatf("rst_busy_u%0d", k), busy_w[k], 0);
            check($sformatf("rst_cnt_u%0d", k), cnt_w[k], 0);
            check($sformatf("rst_ready_u%0d", k), ready_w[k], 1);
        end

        // Single frames: 0xA5 as 8N1 / 8E1 / 8O1, 0x55 as 7N2.
        send_one(0, 8'hA5, 16'h034A);
        send_one(1, 8'hA5, 16'h054A);
        send_one(2, 8'hA5, 16'h074A);
        send_one(3, 8'h55, 16'h03AA);
        wait_idle(0);

        // Back-to-back words, overflow attempt, then hold until a slot frees.
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_hold(0, b2b_data[i], b2b_frame[i], 1'b1, acc);
            check($sformatf("b2b_cnt_%0d", i), cnt_w[0], b2b_cnt[i]);
        end
        @(negedge clk);
        check("ready_when_full", ready_w[0], 0);
        data_w[0]  = b2b_data[5];
        valid_w[0] = 1'b1;
        @(posedge clk); #1;
        check("cnt_ignored_push", cnt_w[0], 4);
        push_hold(0, b2b_data[5], b2b_frame[5], 1'b1, acc);
        check("cnt_refill_after_pop", cnt_w[0], 4);
        wait_idle(0);
        check("b2b_frames_seen", start_q.size(), 6);
        for (int i = 1; i < start_q.size(); i++) begin
            check($sformatf("b2b_gap_%0d", i), start_q[i] - start_q[i-1], 40);
        end

        // Reset in the middle of a data phase with two words still queued.
        push_hold(0, 8'h3C, 16'h0, 1'b0, acc);
        push_hold(0, 8'hC3, 16'h0, 1'b0, acc);
        push_hold(0, 8'h7E, 16'h0, 1'b0, acc);
        check("cnt_before_reset", cnt_w[0], 2);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("tx_low_in_data", busy_w[0], 1);
        rst_epoch++;
        reset = 1'b0;
        #1;
        check("async_rst_tx", tx_w[0], 1);
        check("async_rst_cnt", cnt_w[0], 0);
        check("async_rst_busy", busy_w[0], 0);
        check("async_rst_ready", ready_w[0], 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) lows++;
        end
        check("idle_after_reset", lows, 0);
        check("busy_after_reset", busy_w[0], 0);

        wait_idle(0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter. It generalises the fixed 8N1 transmitter to a configurable number of data bits, a selectable parity mode and 1 or 2 stop bits. It adds a small transmit FIFO with a valid/ready handshake, so the host can queue several words and they go out as back-to-back frames. It pairs with the existing receiver in loopback benches and feeds the serial pin at the chip boundary.

Parameters:
CLKS_PER_BIT, 16, clock cycles per bit period; must be >= 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, number of transmit FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
tx_data  input  DATA_BITS  word to queue for transmission.
tx_valid  input  1  tx_data is valid this cycle.
tx_ready  output  1  FIFO can accept a word this cycle.
tx  output  1  serial line; idles high.
busy  output  1  a frame is in progress or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - tx=1, busy=0, fifo_count=0, tx_ready=1.
  - FSM goes to IDLE; baud counter, bit counter and FIFO pointers clear.
  - A partially sent frame is abandoned and queued words are discarded.
- Push and pop rules:
  - tx_ready = (fifo_count < FIFO_DEPTH), purely combinational from the count.
  - A push occurs on a rising edge where tx_valid && tx_ready.
  - tx_valid while full is ignored and the word is dropped; the host must hold it.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Words are transmitted in push order.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_BITS bits, go to PARITY if PARITY!=0, otherwise STOP.
  - PARITY: tx = XOR of the data word (even mode) or its inverse (odd mode), held CLKS_PER_BIT cycles. Parity is computed from the word when it is popped.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if fifo_count>0, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at the end of each bit; it restarts from 0 on every state entry.
- Latency: a word pushed at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1, and tx falls at E+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx is driven from a register, so the line is glitch-free.
- busy = (state != IDLE) || (fifo_count != 0).
- tx_data bits are used exactly as given; no width extension.
- Reset released mid-stream: the first frame afterwards starts only from a new push.

Test Plan:
- Push 0xA5 with CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1 -> tx goes low one cycle after the push. Bit sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; frame is 40 cycles; busy drops after the stop bit.
- Same word with PARITY=1 -> parity bit 0 before the stop bit; with PARITY=2 -> parity bit 1; frame is 44 cycles.
- STOP_BITS=2, DATA_BITS=7, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then tx high for 8 cycles; total frame 40 cycles.
- Push 5 words 0x01..0x05 back-to-back with FIFO_DEPTH=4:
  - Word 0x01 is popped the cycle after its push, so all five are accepted and fifo_count reaches 4.
  - A sixth tx_valid in the following cycle sees tx_ready=0 and is ignored.
  - All frames go out contiguously (no idle gap) in order 0x01..0x05.
  - Loopback through the existing receiver returns the same five bytes.
- Assert reset=0 mid-DATA with 2 words queued -> tx=1 and fifo_count=0 immediately (asynchronously), busy=0. After release with no push, tx stays high for 100 cycles.
- Full-FIFO simultaneous push/pop: hold tx_valid high at the end of a STOP period while full -> the pop frees a slot, the next push is accepted, and fifo_count returns to 4 with no word lost or duplicated.
